// File: rtl/uart_core_v2.sv
// Full-duplex UART core: independent TX serialiser and RX deserialiser sharing one clock.
// The RX input is synchronised and sampled mid-bit. After a frame error RX waits for the line to go high again.
module uart_core_v2 #(
  parameter int CLOCKS_PER_BIT = 417,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 i_tx_dvalid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_tx_serdata,
  input  logic                 i_rx_serdata,
  output logic                 o_rx_dvalid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err
);

  // state     | meaning
  // IDLE      | TX: line high, ready / RX: waiting for falling edge
  // START     | start bit (RX: half-bit wait to centre sampling)
  // DATA      | payload bits, LSB first
  // PARITY    | parity bit (only when PARITY_MODE != 0)
  // STOP      | STOP_BITS stop bits
  // WAIT_IDLE | RX only: after frame error, wait for line high
  localparam logic [15:0] BIT_LAST  = 16'(CLOCKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        HAS_PAR   = 1'(PARITY_MODE != 0);
  localparam logic        PAR_ODD   = 1'(PARITY_MODE == 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_ser_q, tx_ser_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_done;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_ser_d   = tx_ser_q;
    tx_done    = (tx_cnt_q == 16'd0);
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_done ? BIT_LAST : tx_cnt_q - 16'd1;
    case (tx_state_q)
      TX_IDLE: begin
        if (i_tx_dvalid) begin
          tx_state_d = TX_START;
          tx_cnt_d   = BIT_LAST;
          tx_sh_d    = i_tx_data;
          tx_par_d   = (^i_tx_data) ^ PAR_ODD;
          tx_ser_d   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_done) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
          tx_ser_d   = tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[DATA_BITS-1:1]};
        end
      end
      TX_DATA: begin
        if (tx_done) begin
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d = 3'd0;
            if (HAS_PAR) begin
              tx_state_d = TX_PARITY;
              tx_ser_d   = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_ser_d   = 1'b1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_ser_d = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[DATA_BITS-1:1]};
          end
        end
      end
      TX_PARITY: begin
        if (tx_done) begin
          tx_state_d = TX_STOP;
          tx_bit_d   = 3'd0;
          tx_ser_d   = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_done) begin
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d   = 16'd0;
            tx_bit_d   = 3'd0;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_ser_q   <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_ser_q   <= tx_ser_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign o_tx_ready   = tx_ready_q;
  assign o_tx_serdata = tx_ser_q;

  // sync1/sync2 form the synchroniser; prev_q only feeds edge detection
  logic sync1_q, sync2_q, prev_q;
  logic rx_bit, rx_fall;

  rx_state_e            rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic                 rx_dvalid_q, rx_dvalid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_done, ferr_now;

  assign rx_bit  = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    rx_dvalid_d = 1'b0;
    rx_data_d   = rx_data_q;
    rx_perr_d   = rx_perr_q;
    rx_ferr_d   = rx_ferr_q;
    rx_done     = (rx_cnt_q == 16'd0);
    ferr_now    = ferr_pend_q | ~rx_bit;
    if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_IDLE)
      rx_cnt_d = rx_done ? BIT_LAST : rx_cnt_q - 16'd1;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d  = RX_START;
          rx_cnt_d    = HALF_LAST;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end
      RX_START: begin
        if (rx_done) begin
          if (rx_bit) begin
            rx_state_d = RX_IDLE;
            rx_cnt_d   = 16'd0;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_done) begin
          rx_sh_d = {rx_bit, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d   = 3'd0;
            rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_done) begin
          perr_pend_d = rx_bit ^ (^rx_sh_q) ^ PAR_ODD;
          rx_state_d  = RX_STOP;
          rx_bit_d    = 3'd0;
        end
      end
      RX_STOP: begin
        if (rx_done) begin
          if (rx_bit_q == STOP_LAST) begin
            rx_dvalid_d = 1'b1;
            rx_data_d   = rx_sh_q;
            rx_perr_d   = perr_pend_q;
            rx_ferr_d   = ferr_now;
            rx_state_d  = ferr_now ? RX_WAIT_IDLE : RX_IDLE;
            rx_cnt_d    = 16'd0;
            rx_bit_d    = 3'd0;
          end else begin
            ferr_pend_d = ferr_now;
            rx_bit_d    = rx_bit_q + 3'd1;
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_bit) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_bit_q    <= 3'd0;
      rx_sh_q     <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      rx_dvalid_q <= 1'b0;
      rx_data_q   <= '0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
    end else begin
      sync1_q     <= i_rx_serdata;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      rx_dvalid_q <= rx_dvalid_d;
      rx_data_q   <= rx_data_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
    end
  end

  assign o_rx_dvalid     = rx_dvalid_q;
  assign o_rx_data       = rx_data_q;
  assign o_rx_parity_err = rx_perr_q;
  assign o_rx_frame_err  = rx_ferr_q;

endmodule

// File: doc/uart_core_v2.md
UART_CORE_V2 -- requirements
Module: uart_core_v2

Interface
REQ-001 SHALL provide parameter CLOCKS_PER_BIT, default 417: sys_clk cycles per bit, legal range 8..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8: payload width, legal range 5..8.
REQ-003 SHALL provide parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL provide parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: sys_clk  in  1  rising-edge clock; sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: i_tx_dvalid  in  1  transmit request; i_tx_data  in  DATA_BITS  transmit payload; o_tx_ready  out  1  transmitter can accept; o_tx_serdata  out  1  serial line out.
REQ-007 SHALL have ports: i_rx_serdata  in  1  asynchronous serial line in; o_rx_dvalid  out  1  one-cycle received-word strobe; o_rx_data  out  DATA_BITS  received payload; o_rx_parity_err  out  1  parity mismatch; o_rx_frame_err  out  1  stop bit sampled low.

Function
REQ-008 SHALL frame each word as: start (0), DATA_BITS LSB-first, parity bit if PARITY_MODE!=0, then STOP_BITS stop bits (1); every bit lasts exactly CLOCKS_PER_BIT cycles.
REQ-009 SHALL compute parity as XOR of payload bits (even), or its inverse (odd).
REQ-010 TX states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0.
REQ-011 o_tx_ready SHALL equal 1 only in IDLE; a word is accepted on any cycle where i_tx_dvalid=1 and o_tx_ready=1, and i_tx_data is registered in that cycle.
REQ-012 The start bit SHALL appear on o_tx_serdata the cycle after acceptance.
REQ-013 o_tx_ready SHALL return high the cycle after the final cycle of the last stop bit, so back-to-back words have no gap.
REQ-014 i_tx_dvalid while o_tx_ready=0 SHALL be ignored.
REQ-015 i_rx_serdata SHALL pass through a 2-flop synchroniser whose flops reset to 1; all RX logic SHALL use the synchronised value.
REQ-016 RX states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 IDLE SHALL move to START on a synchronised 1->0 transition.
REQ-018 START SHALL sample at CLOCKS_PER_BIT/2 (integer division); a sample of 1 SHALL be a false start: return to IDLE with no strobe.
REQ-019 Each subsequent bit SHALL be sampled CLOCKS_PER_BIT cycles after the previous sample.
REQ-020 The PARITY sample SHALL set the parity-error result when it differs from the computed parity.
REQ-021 Every stop bit SHALL be sampled; a 0 on any stop bit SHALL set the frame-error result.
REQ-022 o_rx_dvalid SHALL pulse exactly one cycle, the cycle after the last stop-bit sample, with o_rx_data and both error flags updated in that same cycle.
REQ-023 o_rx_data and both error flags SHALL hold their values until the next o_rx_dvalid.
REQ-024 On a frame error RX SHALL enter WAIT_IDLE and re-arm only after sampling a synchronised 1 (break handling); otherwise it SHALL return to IDLE and may detect a new start edge in the cycle after the strobe.
REQ-025 TX and RX SHALL be fully independent; simultaneous activity SHALL NOT interact.

Reset
REQ-026 While sys_rst_n=0, regardless of clock: o_tx_serdata=1, o_tx_ready=1, o_rx_dvalid=0, o_rx_data=0, o_rx_parity_err=0, o_rx_frame_err=0; both FSMs in IDLE; counters 0.
REQ-027 Reset mid-frame SHALL abort both directions immediately; no partial word is strobed; normal operation resumes on the first clock after deassertion.

Verification
Bench parameters: CLOCKS_PER_BIT=16, DATA_BITS=8, PARITY_MODE=1, STOP_BITS=1; TX looped to RX unless stated.
REQ-028 Loopback 0xA5 -> line 0,1,0,1,0,0,1,0,1,0(parity),1 at 16 cycles each; ready low 176 cycles; o_rx_dvalid once with 0xA5, both error flags 0.
REQ-029 Drive RX directly with 0x3C and parity bit 1 -> o_rx_dvalid, o_rx_data=0x3C, o_rx_parity_err=1, o_rx_frame_err=0.
REQ-030 Drive 0x55 with stop bit 0, line held low 100 further cycles -> o_rx_frame_err=1; no new start detected until line returns high; next valid 0x12 received cleanly.
REQ-031 Drive a 5-cycle low glitch on idle RX line -> no o_rx_dvalid; following valid 0x81 received correctly.
REQ-032 Hold i_tx_dvalid=1 with 0x00 then 0xFF -> second word accepted the cycle ready rises; line shows no idle gap; RX strobes 0x00 then 0xFF.
REQ-033 Assert sys_rst_n=0 for 3 cycles during TX/RX bit 4 -> o_tx_serdata=1 and o_tx_ready=1 immediately; no strobe; subsequent 0x7E loopback correct.
